// File: rtl/nanosoc_rst_ctrl.sv
// rtl/nanosoc_rst_ctrl.sv - chip-level reset sequencer: power-on and system resets with cause capture
module nanosoc_rst_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int POR_CYCLES      = 64,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int LOCK_TIMEOUT    = 1024
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic       test_i,
  input  logic       pll_lock_i,
  input  logic       sysresetreq_i,
  input  logic       wdog_rst_req_i,
  input  logic       cause_clr_i,
  output logic       po_nrst_o,
  output logic       sys_nrst_o,
  output logic [3:0] rst_cause_o,
  output logic       rst_busy_o
);

  typedef enum logic [1:0] {
    ST_POR       = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  // One shared counter serves every state; it is cleared on each transition.
  localparam int CNT_MAX_A = (POR_CYCLES > RST_HOLD_CYCLES) ? POR_CYCLES : RST_HOLD_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT) ? CNT_MAX_A : LOCK_TIMEOUT;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [SYNC_STAGES-1:0] rel_sync_q;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   rel_s;
  logic                   lock_s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             po_q, po_d;
  logic             sys_q, sys_d;
  logic [3:0]       cause_q, cause_d;
  logic [3:0]       evt;
  logic             req_any;

  // Reset-release and PLL-lock synchronisers; both clear asynchronously with the pad reset.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      rel_sync_q  <= '0;
      lock_sync_q <= '0;
    end else begin
      rel_sync_q  <= {rel_sync_q[SYNC_STAGES-2:0], 1'b1};
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_lock_i};
    end
  end

  assign rel_s   = rel_sync_q[SYNC_STAGES-1];
  assign lock_s  = lock_sync_q[SYNC_STAGES-1];
  assign req_any = sysresetreq_i | wdog_rst_req_i;

  // Sequencer state, counter, registered reset levels and sticky cause.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q <= ST_POR;
      cnt_q   <= '0;
      po_q    <= 1'b0;
      sys_q   <= 1'b0;
      cause_q <= 4'b0001;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      po_q    <= po_d;
      sys_q   <= sys_d;
      cause_q <= cause_d;
    end
  end

  // Next-state, counter and cause-event decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    po_d    = po_q;
    sys_d   = sys_q;
    evt     = 4'b0000;
    case (state_q)
      ST_POR: begin
        sys_d = 1'b0;
        if (rel_s) begin
          if (cnt_q == POR_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            po_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      ST_WAIT_LOCK: begin
        sys_d = 1'b0;
        if (lock_s) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          evt[3]  = 1'b1;
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HOLD: begin
        sys_d = 1'b0;
        if (cnt_q == HOLD_LAST) begin
          // Counter stays saturated while a request is still asserted.
          if (!req_any) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            sys_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        sys_d  = 1'b1;
        evt[3] = ~lock_s;
        evt[2] = wdog_rst_req_i;
        evt[1] = sysresetreq_i;
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
          sys_d   = 1'b0;
        end else if (req_any) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          sys_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_POR;
        cnt_d   = '0;
      end
    endcase
    cause_d = cause_clr_i ? evt : (cause_q | evt);
  end

  assign po_nrst_o   = test_i ? nrst_i : po_q;
  assign sys_nrst_o  = test_i ? nrst_i : sys_q;
  assign rst_cause_o = cause_q;
  assign rst_busy_o  = (state_q != ST_RUN);

endmodule

// File: tb/tb_nanosoc_rst_ctrl.sv
// tb/tb_nanosoc_rst_ctrl.sv - scoreboard bench for the reset controller
module tb_nanosoc_rst_ctrl;

  localparam int SYNC    = 2;
  localparam int POR     = 64;
  localparam int HOLD    = 16;
  localparam int LOCK_TO = 1024;

  logic       clk      = 1'b0;
  logic       nrst     = 1'b0;
  logic       test     = 1'b0;
  logic       pll_lock = 1'b0;
  logic       sysreq   = 1'b0;
  logic       wdog     = 1'b0;
  logic       clr      = 1'b0;
  logic       po;
  logic       sys;
  logic       busy;
  logic [3:0] cause;

  int unsigned edge_cnt = 0;
  int unsigned base     = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  typedef struct {
    string       tag;
    int unsigned val;
  } exp_t;
  exp_t sb_q[$];

  nanosoc_rst_ctrl #(
    .SYNC_STAGES    (SYNC),
    .POR_CYCLES     (POR),
    .RST_HOLD_CYCLES(HOLD),
    .LOCK_TIMEOUT   (LOCK_TO)
  ) dut (
    .clk_i         (clk),
    .nrst_i        (nrst),
    .test_i        (test),
    .pll_lock_i    (pll_lock),
    .sysresetreq_i (sysreq),
    .wdog_rst_req_i(wdog),
    .cause_clr_i   (clr),
    .po_nrst_o     (po),
    .sys_nrst_o    (sys),
    .rst_cause_o   (cause),
    .rst_busy_o    (busy)
  );

  always #5 clk = ~clk;

  // Free-running edge counter; event times are measured relative to base.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return po;
      1:       return sys;
      2:       return busy;
      default: return cause[3];
    endcase
  endfunction

  task automatic expect_at(input string tag, input int unsigned rel);
    exp_t e;
    e.tag = tag;
    e.val = rel;
    sb_q.push_back(e);
  endtask

  // Wait (bounded) for signal sel to reach lvl, then score its edge time against the queue head.
  task automatic observe(input int sel, input logic lvl, input int bound);
    exp_t        e;
    int unsigned rel = 0;
    bit          hit = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (sig(sel) === lvl) begin
        hit = 1'b1;
        rel = edge_cnt - base;
        break;
      end
    end
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, hit ? rel : 32'hFFFF_FFFF, e.val);
    end
  endtask

  task automatic release_rst();
    nrst = 1'b1;
    base = edge_cnt;
  endtask

  task automatic clear_cause();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("cause_clear", 32'(cause), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got %0d expected %0d", edge_cnt, 0);
    $fatal(1, "bench timeout");
  end

  initial begin
    // Power-on with lock already high: lock_s is settled before WAIT_LOCK is entered.
    pll_lock = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_po", 32'(po), 32'd0);
    check("reset_sys", 32'(sys), 32'd0);
    check("reset_cause", 32'(cause), 32'd1);
    check("reset_busy", 32'(busy), 32'd1);
    release_rst();
    expect_at("po_rise", SYNC + POR);
    observe(0, 1'b1, 200);
    expect_at("sys_rise_lock_high", SYNC + POR + 1 + HOLD);
    observe(1, 1'b1, 200);
    check("run_cause", 32'(cause), 32'd1);
    check("run_busy", 32'(busy), 32'd0);

    // Lock rises together with po_nrst_o: the lock synchroniser latency adds on.
    nrst = 1'b0;
    pll_lock = 1'b0;
    repeat (2) @(negedge clk);
    release_rst();
    expect_at("po_rise_2", SYNC + POR);
    observe(0, 1'b1, 200);
    pll_lock = 1'b1;
    expect_at("sys_rise_late_lock", SYNC + POR + SYNC + 1 + HOLD);
    observe(1, 1'b1, 200);

    // Single-cycle sysresetreq; a watchdog pulse during HOLD must be ignored.
    clear_cause();
    base = edge_cnt;
    sysreq = 1'b1;
    expect_at("sysreq_fall", 1);
    observe(1, 1'b0, 10);
    sysreq = 1'b0;
    repeat (4) @(negedge clk);
    wdog = 1'b1;
    @(negedge clk);
    wdog = 1'b0;
    expect_at("sysreq_rise", 1 + HOLD);
    observe(1, 1'b1, 50);
    check("sysreq_cause", 32'(cause), 32'b0010);
    check("sysreq_po_kept", 32'(po), 32'd1);

    // Coincident watchdog and sysresetreq both recorded.
    clear_cause();
    base = edge_cnt;
    sysreq = 1'b1;
    wdog = 1'b1;
    expect_at("both_fall", 1);
    observe(1, 1'b0, 10);
    sysreq = 1'b0;
    wdog = 1'b0;
    expect_at("both_rise", 1 + HOLD);
    observe(1, 1'b1, 50);
    check("both_cause", 32'(cause), 32'b0110);

    // Watchdog held past the hold time: HOLD waits with the counter saturated.
    clear_cause();
    base = edge_cnt;
    wdog = 1'b1;
    expect_at("sat_fall", 1);
    observe(1, 1'b0, 10);
    repeat (24) @(negedge clk);
    check("sat_sys_low", 32'(sys), 32'd0);
    wdog = 1'b0;
    expect_at("sat_rise", 26);
    observe(1, 1'b1, 50);
    check("sat_cause", 32'(cause), 32'b0100);

    // Lock loss in RUN, then lock returns.
    clear_cause();
    base = edge_cnt;
    pll_lock = 1'b0;
    expect_at("lockloss_fall", SYNC + 1);
    observe(1, 1'b0, 20);
    check("lockloss_busy", 32'(busy), 32'd1);
    repeat (10) @(negedge clk);
    base = edge_cnt;
    pll_lock = 1'b1;
    expect_at("lockback_rise", SYNC + 1 + HOLD);
    observe(1, 1'b1, 60);
    check("lockloss_cause", 32'(cause), 32'b1000);
    check("lockloss_po", 32'(po), 32'd1);

    // PLL never locks: proceed after the timeout with cause[3] set.
    nrst = 1'b0;
    pll_lock = 1'b0;
    repeat (2) @(negedge clk);
    release_rst();
    expect_at("po_rise_to", SYNC + POR);
    observe(0, 1'b1, 200);
    expect_at("lock_timeout_flag", SYNC + POR + LOCK_TO);
    observe(3, 1'b1, LOCK_TO + 100);
    check("timeout_cause", 32'(cause), 32'b1001);
    check("timeout_sys_low", 32'(sys), 32'd0);
    expect_at("timeout_sys_rise", SYNC + POR + LOCK_TO + HOLD);
    observe(1, 1'b1, 100);

    // Asynchronous reset mid-HOLD and mid-POR.
    nrst = 1'b0;
    pll_lock = 1'b1;
    repeat (2) @(negedge clk);
    release_rst();
    expect_at("po_rise_5", SYNC + POR);
    observe(0, 1'b1, 200);
    expect_at("sys_rise_5", SYNC + POR + 1 + HOLD);
    observe(1, 1'b1, 200);
    base = edge_cnt;
    wdog = 1'b1;
    expect_at("hold_entry_fall", 1);
    observe(1, 1'b0, 10);
    wdog = 1'b0;
    repeat (5) @(negedge clk);
    check("midhold_cause_pre", 32'(cause), 32'b0101);
    #1 nrst = 1'b0;
    #1;
    check("midhold_po", 32'(po), 32'd0);
    check("midhold_sys", 32'(sys), 32'd0);
    check("midhold_cause", 32'(cause), 32'd1);
    check("midhold_busy", 32'(busy), 32'd1);
    @(negedge clk);
    release_rst();
    repeat (30) @(negedge clk);
    #1 nrst = 1'b0;
    #1;
    check("midpor_po", 32'(po), 32'd0);
    check("midpor_busy", 32'(busy), 32'd1);
    @(negedge clk);
    release_rst();
    expect_at("po_rise_restart", SYNC + POR);
    observe(0, 1'b1, 200);
    expect_at("sys_rise_restart", SYNC + POR + 1 + HOLD);
    observe(1, 1'b1, 200);
    check("restart_cause", 32'(cause), 32'd1);

    // Test mode: outputs follow nrst_i combinationally, FSM keeps sequencing.
    test = 1'b1;
    @(negedge clk);
    base = edge_cnt;
    #1 nrst = 1'b0;
    #1;
    check("tm_po_low", 32'(po), 32'd0);
    check("tm_sys_low", 32'(sys), 32'd0);
    #1 nrst = 1'b1;
    #1;
    check("tm_po_high", 32'(po), 32'd1);
    check("tm_sys_high", 32'(sys), 32'd1);
    check("tm_busy", 32'(busy), 32'd1);
    expect_at("tm_busy_fall", SYNC + POR + 1 + HOLD);
    observe(2, 1'b0, 200);
    clr = 1'b1;
    wdog = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    wdog = 1'b0;
    check("tm_clr_wdog_cause", 32'(cause), 32'b0100);
    check("tm_sys_bypass", 32'(sys), 32'd1);
    check("tm_busy_hold", 32'(busy), 32'd1);
    test = 1'b0;
    #1;
    check("tm_off_sys", 32'(sys), 32'd0);
    check("tm_off_po", 32'(po), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
